cu_command_arbiter_control: RTL

- Round-robin arbiter and credit scheduler that shares the single CU command buffer between NUM_REQ command-generating engines (data read engine, data write engine, WED/job fetch, …).
- Accepts CommandBufferLine requests over a valid/ready handshake and issues at most one command per cycle to the command buffer.
- Throttles on command-buffer almost-full and on an outstanding-command credit limit.
- Sequences enable/disable by draining all outstanding responses before reporting idle.

---
 rtl/cu_command_arbiter_control.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cu_command_arbiter_control.sv
// rtl/cu_command_arbiter_control.sv - round-robin command arbiter with outstanding-credit throttle
// Shares the single CU command buffer among NUM_REQ engines and drains responses on disable.
module cu_command_arbiter_control #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1),
  parameter int CMD_W           = 32,
  parameter int ID_BITS         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     enabled_in,
  input  logic [NUM_REQ-1:0]       command_in_valid,
  input  logic [NUM_REQ*CMD_W-1:0] command_in_data,
  output logic [NUM_REQ-1:0]       command_ready_out,
  input  logic                     command_buffer_alfull,
  input  logic                     response_in_valid,
  output logic                     command_out_valid,
  output logic [CMD_W-1:0]         command_out_data,
  output logic [ID_BITS-1:0]       grant_id_out,
  output logic [CNT_BITS-1:0]      outstanding_count_out,
  output logic                     drained_out,
  output logic                     error_out
);

  typedef enum logic [1:0] {ST_DISABLED, ST_RUN, ST_DRAIN} state_t;

  localparam logic [CNT_BITS-1:0] MAX_CNT   = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [ID_BITS-1:0]  LAST_ID   = ID_BITS'(NUM_REQ - 1);
  localparam logic [ID_BITS:0]    NUM_REQ_W = (ID_BITS + 1)'(NUM_REQ);

  state_t              state_q, state_d;
  logic                enabled_q, enabled_d;
  logic [ID_BITS-1:0]  ptr_q, ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                error_q, error_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]    cmd_data_q, cmd_data_d;
  logic [ID_BITS-1:0]  grant_id_q, grant_id_d;

  logic                can_grant;
  logic                found;
  logic [ID_BITS-1:0]  sel_id;
  logic [ID_BITS:0]    slot;
  logic [CMD_W-1:0]    sel_data;
  logic [NUM_REQ-1:0]  ready;
  logic                drain_done;
  logic                resp_ok;

  // DRAIN may only fall to DISABLED once the last credit is returned (no grants happen in DRAIN).
  always_comb begin
    state_d    = state_q;
    drain_done = (count_q == '0) || ((count_q == CNT_BITS'(1)) && response_in_valid);
    case (state_q)
      ST_DISABLED: if (enabled_q) state_d = ST_RUN;
      ST_RUN:      if (!enabled_q) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enabled_q)       state_d = ST_RUN;
        else if (drain_done) state_d = ST_DISABLED;
      end
      default:     state_d = ST_DISABLED;
    endcase
  end

  // Arbitrate in the cycle we are entering RUN so a fresh enable grants without an extra bubble.
  always_comb begin
    can_grant = (state_d == ST_RUN) && !command_buffer_alfull && (count_q < MAX_CNT);
    found     = 1'b0;
    sel_id    = '0;
    slot      = '0;
    sel_data  = '0;
    ready     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, ptr_q} + (ID_BITS + 1)'(k);
      if (slot >= NUM_REQ_W) slot = slot - NUM_REQ_W;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (can_grant && !found && (slot == (ID_BITS + 1)'(j)) && command_in_valid[j]) begin
          found  = 1'b1;
          sel_id = ID_BITS'(j);
        end
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      ready[j] = found && (sel_id == ID_BITS'(j));
      if (ready[j]) sel_data = command_in_data[j*CMD_W +: CMD_W];
    end
  end

  always_comb begin
    enabled_d = enabled_in;
    resp_ok   = response_in_valid && (count_q != '0);
    count_d   = count_q;
    if (found && !resp_ok)      count_d = count_q + 1'b1;
    else if (!found && resp_ok) count_d = count_q - 1'b1;
    error_d     = error_q | (response_in_valid && (count_q == '0));
    ptr_d       = ptr_q;
    if (found) ptr_d = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
    cmd_valid_d = found;
    cmd_data_d  = found ? sel_data : '0;
    grant_id_d  = found ? sel_id : '0;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_DISABLED;
      enabled_q   <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      enabled_q   <= enabled_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign command_ready_out     = ready;
  assign command_out_valid     = cmd_valid_q;
  assign command_out_data      = cmd_data_q;
  assign grant_id_out          = grant_id_q;
  assign outstanding_count_out = count_q;
  assign drained_out           = (state_q == ST_DISABLED) && (count_q == '0);
  assign error_out             = error_q;

endmodule
